// File: rtl/spi_slave_cmd_sequencer_if.sv
// Signal bundle between the SPI command sequencer and the PHY, CSR bus, PSRAM bus and CPU.
// The slave modport is the sequencer's view; master is the view of whatever surrounds it.
`timescale 1ns/1ps
interface spi_slave_cmd_sequencer_if #(
   parameter int pUsiAdrsBit = 16,
   parameter int pUfiAdrsBit = 32
);
   logic                   iCsn;
   logic [7:0]             iRxByte;
   logic                   iRxVd;
   logic [7:0]             oTxByte;
   logic                   iTxAck;
   logic [31:0]            oMUsiWd;
   logic [pUsiAdrsBit-1:0] oMUsiAdrs;
   logic                   oMUsiWEd;
   logic                   oMUsiRReq;
   logic [31:0]            iMUsiRd;
   logic                   iMUsiREd;
   logic [31:0]            oMUfiWd;
   logic [pUfiAdrsBit-1:0] oMUfiAdrs;
   logic                   oMUfiWEd;
   logic                   oMUfiWVd;
   logic                   oMSpiIntr;
   logic [3:0]             oErrSts;
   logic                   iErrClr;

   modport slave (
      input  iCsn, iRxByte, iRxVd, iTxAck, iMUsiRd, iMUsiREd, iErrClr,
      output oTxByte, oMUsiWd, oMUsiAdrs, oMUsiWEd, oMUsiRReq,
             oMUfiWd, oMUfiAdrs, oMUfiWEd, oMUfiWVd, oMSpiIntr, oErrSts
   );

   modport master (
      output iCsn, iRxByte, iRxVd, iTxAck, iMUsiRd, iMUsiREd, iErrClr,
      input  oTxByte, oMUsiWd, oMUsiAdrs, oMUsiWEd, oMUsiRReq,
             oMUfiWd, oMUfiAdrs, oMUfiWEd, oMUfiWVd, oMSpiIntr, oErrSts
   );
endinterface

// File: rtl/spi_slave_cmd_sequencer.sv
// Parses one SPI CS frame (8-byte header + payload) and dispatches it as a CSR write,
// a CSR read returned through the PHY shifter, or a PSRAM word-write burst.
`timescale 1ns/1ps
module spi_slave_cmd_sequencer #(
   parameter int pUsiAdrsBit    = 16,
   parameter int pUfiAdrsBit    = 32,
   parameter int pMaxMemLen     = 2048,
   parameter int pTimeoutCycles = 256
) (
   input logic                      iSysClk,
   input logic                      iSysRst,
   spi_slave_cmd_sequencer_if.slave bus
);

   localparam int                     lToBit   = $clog2(pTimeoutCycles + 1);
   localparam logic [lToBit-1:0]      lToLast  = lToBit'(pTimeoutCycles - 1);
   localparam logic [15:0]            lMaxLen  = 16'(pMaxMemLen);
   localparam logic [pUfiAdrsBit-1:0] lUfiStep = pUfiAdrsBit'(4);

   typedef enum logic [2:0] {
      IDLE, HDR, CSRW, CSRR_REQ, CSRR_WAIT, CSRR_TX, MEMW, DRAIN
   } state_t;

   state_t                 r_state;
   logic                   r_arm;
   logic [2:0]             r_hdr_cnt;
   logic [31:0]            r_adrs;
   logic [7:0]             r_cmd;
   logic [15:0]            r_len;
   logic [11:0]            r_byte_cnt;
   logic [31:0]            r_word;
   logic [31:0]            r_rd_sh;
   logic [1:0]             r_tx_idx;
   logic [lToBit-1:0]      r_to_cnt;
   logic [pUfiAdrsBit-1:0] r_ufi_next;

   logic [7:0]             r_tx_byte;
   logic [31:0]            r_usi_wd;
   logic [pUsiAdrsBit-1:0] r_usi_adrs;
   logic                   r_usi_wed;
   logic                   r_usi_rreq;
   logic [31:0]            r_ufi_wd;
   logic [pUfiAdrsBit-1:0] r_ufi_adrs;
   logic                   r_ufi_wed;
   logic                   r_ufi_wvd;
   logic                   r_intr;
   logic [3:0]             r_err;

   logic                   w_rx;
   logic [31:0]            w_word_next;
   logic [11:0]            w_cnt_next;
   logic                   w_mem_len_bad;
   logic                   w_in_frame;

   assign w_rx          = bus.iRxVd & ~bus.iCsn;
   assign w_word_next   = {r_word[23:0], bus.iRxByte};
   assign w_cnt_next    = r_byte_cnt + 12'd1;
   assign w_mem_len_bad = (r_len > lMaxLen) || (r_len[1:0] != 2'b00);
   assign w_in_frame    = (r_state != IDLE) && (r_state != DRAIN);

   // r_arm blocks a frame from starting until CS has been seen high, so a reset
   // in the middle of a frame cannot reinterpret the payload tail as a header.
   always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
         r_state    <= IDLE;
         r_arm      <= 1'b0;
         r_hdr_cnt  <= '0;
         r_adrs     <= '0;
         r_cmd      <= '0;
         r_len      <= '0;
         r_byte_cnt <= '0;
         r_word     <= '0;
         r_rd_sh    <= '0;
         r_tx_idx   <= '0;
         r_to_cnt   <= '0;
         r_ufi_next <= '0;
         r_tx_byte  <= '0;
         r_usi_wd   <= '0;
         r_usi_adrs <= '0;
         r_usi_wed  <= 1'b0;
         r_usi_rreq <= 1'b0;
         r_ufi_wd   <= '0;
         r_ufi_adrs <= '0;
         r_ufi_wed  <= 1'b0;
         r_ufi_wvd  <= 1'b0;
         r_intr     <= 1'b0;
         r_err      <= '0;
      end else begin
         r_usi_wed  <= 1'b0;
         r_usi_rreq <= 1'b0;
         r_ufi_wed  <= 1'b0;
         r_intr     <= 1'b0;
         // A clear is overridden bit-wise by any error set later in this block.
         if (bus.iErrClr)
            r_err <= '0;
         if (bus.iCsn)
            r_arm <= 1'b1;

         if (bus.iCsn) begin
            if (w_in_frame)
               r_err[2] <= 1'b1;
            r_state    <= IDLE;
            r_ufi_wvd  <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_hdr_cnt  <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_tx_idx   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (r_arm) begin
                     r_state   <= HDR;
                     r_hdr_cnt <= '0;
                  end
               end

               HDR: begin
                  if (w_rx) begin
                     r_hdr_cnt <= r_hdr_cnt + 3'd1;
                     case (r_hdr_cnt)
                        3'd0, 3'd1, 3'd2, 3'd3: r_adrs <= {r_adrs[23:0], bus.iRxByte};
                        3'd4:                   r_cmd  <= bus.iRxByte;
                        3'd5, 3'd6:             r_len  <= {r_len[7:0], bus.iRxByte};
                        default: begin
                           r_byte_cnt <= '0;
                           case (r_cmd)
                              8'd0: r_state <= DRAIN;
                              8'd1: begin
                                 if (r_len == 16'd4) begin
                                    r_state <= CSRW;
                                 end else begin
                                    r_err[1] <= 1'b1;
                                    r_state  <= DRAIN;
                                 end
                              end
                              8'd2: begin
                                 if (r_len == 16'd4) begin
                                    r_state    <= CSRR_REQ;
                                    r_usi_rreq <= 1'b1;
                                    r_usi_adrs <= r_adrs[pUsiAdrsBit-1:0];
                                    r_to_cnt   <= '0;
                                 end else begin
                                    r_err[1] <= 1'b1;
                                    r_state  <= DRAIN;
                                 end
                              end
                              8'd3: begin
                                 if (w_mem_len_bad) begin
                                    r_err[1] <= 1'b1;
                                    r_state  <= DRAIN;
                                 end else begin
                                    r_state    <= MEMW;
                                    r_ufi_next <= r_adrs[pUfiAdrsBit-1:0];
                                    r_ufi_wvd  <= (r_len != 16'd0);
                                 end
                              end
                              default: begin
                                 r_err[0] <= 1'b1;
                                 r_state  <= DRAIN;
                              end
                           endcase
                        end
                     endcase
                  end
               end

               CSRW: begin
                  if (w_rx) begin
                     r_word     <= w_word_next;
                     r_byte_cnt <= w_cnt_next;
                     if (r_byte_cnt[1:0] == 2'd3) begin
                        r_usi_wd   <= w_word_next;
                        r_usi_adrs <= r_adrs[pUsiAdrsBit-1:0];
                        r_usi_wed  <= 1'b1;
                        r_intr     <= 1'b1;
                        r_state    <= DRAIN;
                     end
                  end
               end

               CSRR_REQ: r_state <= CSRR_WAIT;

               CSRR_WAIT: begin
                  if (bus.iMUsiREd) begin
                     r_rd_sh   <= {bus.iMUsiRd[23:0], 8'h00};
                     r_tx_byte <= bus.iMUsiRd[31:24];
                     r_tx_idx  <= '0;
                     r_state   <= CSRR_TX;
                  end else if (r_to_cnt == lToLast) begin
                     r_err[3] <= 1'b1;
                     r_state  <= DRAIN;
                  end else begin
                     r_to_cnt <= r_to_cnt + lToBit'(1);
                  end
               end

               CSRR_TX: begin
                  if (bus.iTxAck) begin
                     if (r_tx_idx == 2'd3) begin
                        r_tx_byte <= 8'h00;
                        r_intr    <= 1'b1;
                        r_state   <= DRAIN;
                     end else begin
                        r_tx_byte <= r_rd_sh[31:24];
                        r_rd_sh   <= {r_rd_sh[23:0], 8'h00};
                        r_tx_idx  <= r_tx_idx + 2'd1;
                     end
                  end
               end

               // The window stays open through the last write; DRAIN closes it a cycle later.
               MEMW: begin
                  if (r_len == 16'd0) begin
                     r_intr  <= 1'b1;
                     r_state <= DRAIN;
                  end else if (w_rx) begin
                     r_word     <= w_word_next;
                     r_byte_cnt <= w_cnt_next;
                     if (r_byte_cnt[1:0] == 2'd3) begin
                        r_ufi_wd   <= w_word_next;
                        r_ufi_adrs <= r_ufi_next;
                        r_ufi_next <= r_ufi_next + lUfiStep;
                        r_ufi_wed  <= 1'b1;
                     end
                     if ({4'd0, w_cnt_next} == r_len) begin
                        r_intr  <= 1'b1;
                        r_state <= DRAIN;
                     end
                  end
               end

               DRAIN: begin
                  r_ufi_wvd <= 1'b0;
                  r_tx_byte <= 8'h00;
               end

               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.oTxByte   = r_tx_byte;
   assign bus.oMUsiWd   = r_usi_wd;
   assign bus.oMUsiAdrs = r_usi_adrs;
   assign bus.oMUsiWEd  = r_usi_wed;
   assign bus.oMUsiRReq = r_usi_rreq;
   assign bus.oMUfiWd   = r_ufi_wd;
   assign bus.oMUfiAdrs = r_ufi_adrs;
   assign bus.oMUfiWEd  = r_ufi_wed;
   assign bus.oMUfiWVd  = r_ufi_wvd;
   assign bus.oMSpiIntr = r_intr;
   assign bus.oErrSts   = r_err;

endmodule

// File: tb/tb_spi_slave_cmd_sequencer.sv
// Randomized frame-level bench for spi_slave_cmd_sequencer; expected bus traffic and
// error flags come from a per-frame model of the header/payload rules.
`timescale 1ns/1ps
module tb_spi_slave_cmd_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_slave_cmd_sequencer_if #(.pUsiAdrsBit(16), .pUfiAdrsBit(32)) bus ();

   spi_slave_cmd_sequencer #(
      .pUsiAdrsBit(16), .pUfiAdrsBit(32), .pMaxMemLen(2048), .pTimeoutCycles(256)
   ) dut (
      .iSysClk(clk),
      .iSysRst(rst),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Observed traffic
   logic [47:0] usi_q[$];
   logic [63:0] ufi_q[$];
   int          intr_cnt = 0;
   int          rreq_cnt = 0;
   logic        prev_done = 1'b0;

   // Expected traffic
   logic [47:0] exp_usi[$];
   logic [63:0] exp_ufi[$];
   int          exp_intr = 0;
   logic [3:0]  exp_err = 4'h0;
   logic [7:0]  dq[$];

   always @(negedge clk) begin
      if (bus.oMUsiWEd) usi_q.push_back({bus.oMUsiAdrs, bus.oMUsiWd});
      if (bus.oMUfiWEd) begin
         ufi_q.push_back({bus.oMUfiAdrs, bus.oMUfiWd});
         check_eq("wvd_with_wed", 64'(bus.oMUfiWVd), 64'd1);
      end
      if (prev_done) check_eq("wvd_fall", 64'(bus.oMUfiWVd), 64'd0);
      prev_done = bus.oMUfiWEd & bus.oMSpiIntr;
      if (bus.oMSpiIntr) intr_cnt++;
      if (bus.oMUsiRReq) rreq_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      usi_q.delete(); ufi_q.delete(); intr_cnt = 0; rreq_cnt = 0;
      exp_usi.delete(); exp_ufi.delete(); exp_intr = 0;
   endtask

   task automatic fill_rand(input int n);
      dq.delete();
      repeat (n) dq.push_back(8'($urandom));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit clr);
      repeat ($urandom_range(0, 2)) tick();
      bus.iRxByte = b; bus.iRxVd = 1'b1; bus.iErrClr = clr;
      tick();
      bus.iRxVd = 1'b0; bus.iErrClr = 1'b0; bus.iRxByte = 8'($urandom);
   endtask

   task automatic send_hdr(input logic [31:0] adrs, input logic [7:0] cmd, input logic [15:0] len);
      logic [7:0] h[$];
      h = {adrs[31:24], adrs[23:16], adrs[15:8], adrs[7:0], cmd, len[15:8], len[7:0], 8'($urandom)};
      foreach (h[i]) send_byte(h[i], 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_tx"},   64'(bus.oTxByte),   64'd0);
      check_eq({tag, "_uwd"},  64'(bus.oMUsiWd),   64'd0);
      check_eq({tag, "_uadr"}, 64'(bus.oMUsiAdrs), 64'd0);
      check_eq({tag, "_uwed"}, 64'(bus.oMUsiWEd),  64'd0);
      check_eq({tag, "_rreq"}, 64'(bus.oMUsiRReq), 64'd0);
      check_eq({tag, "_fwd"},  64'(bus.oMUfiWd),   64'd0);
      check_eq({tag, "_fadr"}, 64'(bus.oMUfiAdrs), 64'd0);
      check_eq({tag, "_fwed"}, 64'(bus.oMUfiWEd),  64'd0);
      check_eq({tag, "_wvd"},  64'(bus.oMUfiWVd),  64'd0);
      check_eq({tag, "_intr"}, 64'(bus.oMSpiIntr), 64'd0);
      check_eq({tag, "_err"},  64'(bus.oErrSts),   64'd0);
   endtask

   // Frame model: header fields plus how many bytes made it out before CS rose.
   task automatic model_frame(input logic [31:0] adrs, input logic [7:0] cmd, input logic [15:0] len,
                              input int nsent, input bit clr7, output bit wvd_open);
      logic [3:0] ferr;
      int d, lim;
      ferr = 4'h0;
      wvd_open = 1'b0;
      if (clr7 && nsent >= 8) exp_err = 4'h0;
      if (nsent < 8) ferr[2] = 1'b1;
      else begin
         d = nsent - 8;
         case (cmd)
            8'd0: ;
            8'd1: begin
               if (len != 16'd4) ferr[1] = 1'b1;
               else if (d >= 4) begin
                  exp_usi.push_back({adrs[15:0], dq[0], dq[1], dq[2], dq[3]});
                  exp_intr = 1;
               end else ferr[2] = 1'b1;
            end
            8'd3: begin
               if (len > 16'd2048 || len[1:0] != 2'b00) ferr[1] = 1'b1;
               else if (len == 16'd0) exp_intr = 1;
               else begin
                  lim = (d < int'(len)) ? d : int'(len);
                  for (int k = 0; k + 4 <= lim; k += 4)
                     exp_ufi.push_back({adrs + 32'(k), dq[k], dq[k+1], dq[k+2], dq[k+3]});
                  if (d >= int'(len)) exp_intr = 1;
                  else begin
                     ferr[2] = 1'b1;
                     wvd_open = 1'b1;
                  end
               end
            end
            default: ferr[0] = 1'b1;
         endcase
      end
      exp_err |= ferr;
   endtask

   task automatic compare_frame();
      check_eq("usi_cnt", 64'(usi_q.size()), 64'(exp_usi.size()));
      for (int i = 0; i < exp_usi.size() && i < usi_q.size(); i++)
         check_eq("usi_wr", 64'(usi_q[i]), 64'(exp_usi[i]));
      check_eq("ufi_cnt", 64'(ufi_q.size()), 64'(exp_ufi.size()));
      for (int i = 0; i < exp_ufi.size() && i < ufi_q.size(); i++)
         check_eq("ufi_wr", ufi_q[i], exp_ufi[i]);
      check_eq("intr_cnt", 64'(intr_cnt), 64'(exp_intr));
      check_eq("rreq_cnt", 64'(rreq_cnt), 64'd0);
      check_eq("err_sts", 64'(bus.oErrSts), 64'(exp_err));
   endtask

   // Payload comes from dq; cut < 0 sends the whole frame, otherwise CS rises after cut bytes.
   task automatic do_frame(input logic [31:0] adrs, input logic [7:0] cmd, input logic [15:0] len,
                           input int cut, input bit clr7);
      logic [7:0] fb[$];
      int nsent;
      bit open;
      fb = {adrs[31:24], adrs[23:16], adrs[15:8], adrs[7:0], cmd, len[15:8], len[7:0], 8'($urandom)};
      foreach (dq[i]) fb.push_back(dq[i]);
      nsent = (cut < 0 || cut > fb.size()) ? fb.size() : cut;
      clear_mon();
      model_frame(adrs, cmd, len, nsent, clr7, open);
      bus.iCsn = 1'b0;
      tick();
      for (int i = 0; i < nsent; i++) send_byte(fb[i], clr7 && (i == 7));
      repeat (4) tick();
      if (open) check_eq("wvd_open", 64'(bus.oMUfiWVd), 64'd1);
      bus.iCsn = 1'b1;
      tick();
      check_eq("wvd_cs_hi", 64'(bus.oMUfiWVd), 64'd0);
      repeat (2) tick();
      compare_frame();
   endtask

   task automatic do_read(input logic [31:0] adrs, input logic [31:0] data, input int dly, input bit respond);
      bit found;
      clear_mon();
      bus.iCsn = 1'b0;
      tick();
      send_hdr(adrs, 8'd2, 16'd4);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.oMUsiRReq) found = 1'b1;
         else tick();
      end
      check_eq("rreq_seen", 64'(found), 64'd1);
      if (found) begin
         check_eq("rreq_adrs", 64'(bus.oMUsiAdrs), 64'(adrs[15:0]));
         if (respond) begin
            repeat (dly) tick();
            check_eq("tx_wait", 64'(bus.oTxByte), 64'd0);
            bus.iMUsiRd = data; bus.iMUsiREd = 1'b1;
            tick();
            bus.iMUsiREd = 1'b0; bus.iMUsiRd = $urandom;
            for (int k = 0; k < 4; k++) begin
               repeat ($urandom_range(0, 3)) tick();
               check_eq("tx_byte", 64'(bus.oTxByte), 64'(data[31-8*k -: 8]));
               bus.iTxAck = 1'b1;
               tick();
               bus.iTxAck = 1'b0;
            end
            repeat (3) tick();
            check_eq("rd_intr", 64'(intr_cnt), 64'd1);
         end else begin
            repeat (200) tick();
            check_eq("to_early", 64'(bus.oErrSts[3]), 64'd0);
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
               if (bus.oErrSts[3]) found = 1'b1;
               else tick();
            end
            check_eq("to_set", 64'(found), 64'd1);
            exp_err[3] = 1'b1;
            check_eq("to_intr", 64'(intr_cnt), 64'd0);
         end
      end
      bus.iCsn = 1'b1;
      repeat (3) tick();
      check_eq("rd_rreq_cnt", 64'(rreq_cnt), 64'd1);
      check_eq("rd_no_wr", 64'(usi_q.size() + ufi_q.size()), 64'd0);
      check_eq("rd_err", 64'(bus.oErrSts), 64'(exp_err));
   endtask

   task automatic pulse_clr();
      bus.iErrClr = 1'b1;
      tick();
      bus.iErrClr = 1'b0;
      exp_err = 4'h0;
      check_eq("err_clr", 64'(bus.oErrSts), 64'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, ndata, cut;
      logic [15:0] len;
      logic [7:0]  cmd;
      bus.iCsn = 1'b1; bus.iRxByte = 8'h00; bus.iRxVd = 1'b0; bus.iTxAck = 1'b0;
      bus.iMUsiRd = 32'h0; bus.iMUsiREd = 1'b0; bus.iErrClr = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_outputs_zero("reset");

      // CSR write from the test plan
      dq = {8'h00, 8'h00, 8'h00, 8'hAA};
      do_frame(32'h87650304, 8'd1, 16'd4, -1, 1'b0);

      // CSR read with a response, then without one
      do_read(32'h00000308, 32'h12345678, 5, 1'b1);
      do_read(32'h00000308, 32'h0, 0, 1'b0);
      pulse_clr();

      // PSRAM write of two words
      dq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      do_frame(32'h00001000, 8'd3, 16'd8, -1, 1'b0);

      // Length and command errors
      fill_rand(4);
      do_frame(32'h00000010, 8'd1, 16'd2, -1, 1'b0);
      fill_rand(8);
      do_frame(32'h00000020, 8'd3, 16'd2052, -1, 1'b0);
      do_frame(32'h00000030, 8'd9, 16'd4, -1, 1'b0);
      pulse_clr();
      do_frame(32'h00000040, 8'd9, 16'd0, -1, 1'b0);
      do_frame(32'h00000050, 8'd9, 16'd0, -1, 1'b1);
      pulse_clr();

      // Abort after six payload bytes, then a clean frame
      fill_rand(8);
      do_frame(32'h00002000, 8'd3, 16'd8, 14, 1'b0);
      fill_rand(4);
      do_frame(32'h00003004, 8'd1, 16'd4, -1, 1'b0);
      pulse_clr();

      // Extra payload bytes after a CSR write are ignored
      fill_rand(8);
      do_frame(32'h0000ABCD, 8'd1, 16'd4, -1, 1'b0);

      // PSRAM write with zero length and address wrap
      dq.delete();
      do_frame(32'h00000100, 8'd3, 16'd0, -1, 1'b0);
      fill_rand(12);
      do_frame(32'hFFFFFFF8, 8'd3, 16'd12, -1, 1'b0);

      // Reset in the middle of a PSRAM burst, with CS kept low afterwards
      clear_mon();
      bus.iCsn = 1'b0;
      tick();
      send_hdr(32'h00004000, 8'd3, 16'd16);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outputs_zero("midrst");
      exp_err = 4'h0;
      clear_mon();
      for (int i = 0; i < 14; i++) send_byte(8'($urandom), 1'b0);
      repeat (4) tick();
      check_eq("midrst_usi", 64'(usi_q.size()), 64'd0);
      check_eq("midrst_ufi", 64'(ufi_q.size()), 64'd0);
      check_eq("midrst_intr", 64'(intr_cnt), 64'd0);
      check_eq("midrst_rreq", 64'(rreq_cnt), 64'd0);
      bus.iCsn = 1'b1;
      repeat (3) tick();
      check_eq("midrst_err", 64'(bus.oErrSts), 64'd0);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 6);
         cut  = -1;
         len  = 16'd4;
         cmd  = 8'd0;
         ndata = 4;
         case (kind)
            0: begin cmd = 8'd0; ndata = $urandom_range(0, 4); end
            1: begin cmd = 8'd1; ndata = $urandom_range(4, 8); end
            2: begin cmd = 8'd1; len = 16'($urandom_range(5, 60)); end
            3: begin
               cmd = 8'd3; len = 16'(4 * $urandom_range(0, 8));
               ndata = int'(len) + $urandom_range(0, 4);
            end
            4: begin
               cmd = 8'd3; ndata = 8;
               len = ($urandom_range(0, 1) == 1) ? 16'(2052 + 4 * $urandom_range(0, 100))
                                                 : 16'(4 * $urandom_range(0, 8) + $urandom_range(1, 3));
            end
            5: begin cmd = 8'($urandom_range(4, 255)); ndata = $urandom_range(0, 4); end
            default: ;
         endcase
         if (kind == 6) begin
            do_read($urandom, $urandom, $urandom_range(1, 10), 1'b1);
         end else begin
            fill_rand(ndata);
            if ($urandom_range(0, 4) == 0) cut = $urandom_range(0, 7 + ndata);
            do_frame($urandom, cmd, len, cut, 1'b0);
         end
         if ($urandom_range(0, 3) == 0) pulse_clr();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
